// File: rtl/svr_mac_engine.sv
// Time-multiplexed linear SVR: y = bias + sum(w[i]*x[i]) over N_FEAT single-precision features,
// one shared FP multiplier and adder, one feature per clock, runtime-writable coefficients.
module svr_mac_engine #(
    parameter int unsigned            N_FEAT = 9,
    parameter int unsigned            IDX_W  = 4,
    parameter logic [32*N_FEAT-1:0]   W_INIT = {32'h3EEE8A72, 32'hBFAFD567, 32'hBF2A92A3,
                                                32'h41427C1C, 32'h40CCBAC7, 32'h3FB08312,
                                                32'h403F9A6B, 32'h3F13D07D, 32'h3E5A0275},
    parameter logic [31:0]            B_INIT = 32'hC3C00E4C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [32*N_FEAT-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           y,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cfg_we,
    input  logic [IDX_W-1:0]      cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic                  busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(N_FEAT - 1);
    localparam logic [IDX_W-1:0] BiasAddr = IDX_W'(N_FEAT);
    localparam logic [31:0]      QNan     = 32'h7FC00000;

    // Round-to-nearest-even multiply; denormal inputs and results flush to signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [7:0]        ea, eb;
        logic [47:0]       prod;
        logic [22:0]       frac;
        logic              g, st;
        logic [23:0]       rnd;
        logic signed [9:0] e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0)) return QNan;
        if (ea == 8'hFF || eb == 8'hFF) begin
            if (ea == 8'h00 || eb == 8'h00) return QNan;
            return {s, 8'hFF, 23'b0};
        end
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'b0};
        prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e    = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
        if (prod[47]) begin
            frac = prod[46:24];
            g    = prod[23];
            st   = |prod[22:0];
            e    = e + 10'sd1;
        end else begin
            frac = prod[45:23];
            g    = prod[22];
            st   = |prod[21:0];
        end
        rnd = {1'b0, frac} + {23'b0, g & (st | frac[0])};
        if (rnd[23]) e = e + 10'sd1;
        if (e >= 10'sd255) return {s, 8'hFF, 23'b0};
        if (e <= 10'sd0) return {s, 31'b0};
        return {s, e[7:0], rnd[22:0]};
    endfunction

    // Round-to-nearest-even add with guard/round/sticky alignment; exact cancellation gives +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic              swap, s_big;
        logic [7:0]        e_big, e_sml, d;
        logic [26:0]       m_big, m_full, m_sml, mask, norm;
        logic [27:0]       sum;
        logic [23:0]       rnd;
        logic [4:0]        lz;
        logic signed [9:0] e;
        a_nan  = a[30:23] == 8'hFF && a[22:0] != '0;
        b_nan  = b[30:23] == 8'hFF && b[22:0] != '0;
        a_inf  = a[30:23] == 8'hFF && a[22:0] == '0;
        b_inf  = b[30:23] == 8'hFF && b[22:0] == '0;
        a_zero = a[30:23] == 8'h00;
        b_zero = b[30:23] == 8'h00;
        if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return QNan;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'b0};
        if (a_zero) return b;
        if (b_zero) return a;
        swap   = b[30:0] > a[30:0];
        s_big  = swap ? b[31] : a[31];
        e_big  = swap ? b[30:23] : a[30:23];
        e_sml  = swap ? a[30:23] : b[30:23];
        m_big  = {1'b1, swap ? b[22:0] : a[22:0], 3'b000};
        m_full = {1'b1, swap ? a[22:0] : b[22:0], 3'b000};
        d      = e_big - e_sml;
        if (d >= 8'd27) begin
            m_sml = 27'd1;
        end else begin
            mask  = (27'd1 << d) - 27'd1;
            m_sml = (m_full >> d) | {26'b0, |(m_full & mask)};
        end
        if (a[31] ^ b[31]) sum = {1'b0, m_big} - {1'b0, m_sml};
        else               sum = {1'b0, m_big} + {1'b0, m_sml};
        if (sum == '0) return 32'h0;
        e = $signed({2'b0, e_big});
        if (sum[27]) begin
            norm = sum[27:1] | {26'b0, sum[0]};
            e    = e + 10'sd1;
        end else begin
            lz = 5'd0;
            for (int i = 0; i < 27; i++) begin
                if (sum[i]) lz = 5'(26 - i);
            end
            norm = sum[26:0] << lz;
            e    = e - $signed({5'b0, lz});
        end
        rnd = {1'b0, norm[25:3]} + {23'b0, norm[2] & ((|norm[1:0]) | norm[3])};
        if (rnd[23]) e = e + 10'sd1;
        if (e >= 10'sd255) return {s_big, 8'hFF, 23'b0};
        if (e <= 10'sd0) return {s_big, 31'b0};
        return {s_big, e[7:0], rnd[22:0]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      x_q [N_FEAT];
    logic [31:0]      w_q [N_FEAT];
    logic [31:0]      bias_q;
    logic             accept, cfg_ok;
    logic [31:0]      bias_in, prod, mac_sum;

    assign in_ready  = state_q == StIdle;
    assign busy      = state_q != StIdle;
    assign out_valid = state_q == StDone;
    assign y         = acc_q;

    assign accept = in_valid && in_ready;
    assign cfg_ok = cfg_we && (state_q == StIdle) && (cfg_addr <= BiasAddr);
    // A bias write on the acceptance edge seeds this computation, like a weight write would.
    assign bias_in = (cfg_ok && cfg_addr == BiasAddr) ? cfg_wdata : bias_q;
    assign prod    = fp_mul(w_q[idx_q], x_q[idx_q]);
    assign mac_sum = fp_add(acc_q, prod);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    idx_d   = '0;
                    acc_d   = bias_in;
                end
            end
            StRun: begin
                acc_d = mac_sum;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_FEAT); i++) x_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < int'(N_FEAT); i++) x_q[i] <= in_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_FEAT); i++) w_q[i] <= W_INIT[32*i +: 32];
            bias_q <= B_INIT;
        end else if (cfg_ok) begin
            if (cfg_addr == BiasAddr) bias_q <= cfg_wdata;
            else                      w_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: doc/svr_mac_engine.md
Name: svr_mac_engine

Overview:
Parametrised, time-multiplexed successor to the combinational 9-input linear SVR datapath. Computes y = bias + sum(w[i]*x[i]) for N_FEAT IEEE-754 single-precision features using one shared IEEE754_multiplier and one IEEE754_adder, iterating one feature per clock. Coefficients and bias live in a runtime-writable register file initialised from parameters. Sits between the feature-capture front end and the prediction output stage, with valid/ready handshakes on both sides.

Parameters:
N_FEAT, 9, number of features (1..15)
IDX_W, 4, width of feature index and config address; must satisfy 2^IDX_W > N_FEAT
W_INIT, {32'h3EEE8A72,32'hBFAFD567,32'hBF2A92A3,32'h41427C1C,32'h40CCBAC7,32'h3FB08312,32'h403F9A6B,32'h3F13D07D,32'h3E5A0275}, packed reset weights, 32*N_FEAT bits, w[0] in [31:0]
B_INIT, 32'hC3C00E4C, reset bias (-384.1117)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_data  in  32*N_FEAT  feature vector, x[i] in bits [32i+31:32i]
in_valid  in  1  in_data valid
in_ready  out  1  engine can accept a vector
y  out  32  prediction, IEEE-754 single
out_valid  out  1  y valid
out_ready  in  1  downstream accepts y
cfg_we  in  1  coefficient write strobe
cfg_addr  in  IDX_W  0..N_FEAT-1 selects w[addr]; N_FEAT selects bias
cfg_wdata  in  32  coefficient value
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=0, y=0, out_valid=0, in_ready=1, busy=0, w[i]=W_INIT slice, bias=B_INIT, x register cleared.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); busy = !IDLE; out_valid = (state==DONE); y = acc.
- IDLE: on in_valid&&in_ready edge: latch in_data into x register, acc<=bias, idx<=0, ->RUN. in_data may change after this edge.
- RUN: each edge acc <= fp_add(acc, fp_mul(w[idx], x[idx])); idx<=idx+1; at idx==N_FEAT-1 ->DONE (idx back to 0). Multiplier and adder combinational, single cycle.
- Accumulation order fixed: bias first, then i=0..N_FEAT-1. Results may differ in LSBs from the tree-adder block; bench model must use this order.
- DONE: y and out_valid held stable until out_valid&&out_ready edge, then ->IDLE. No new input accepted in DONE.
- Latency: out_valid high exactly N_FEAT edges after the acceptance edge. Throughput with out_ready tied high: one result per N_FEAT+2 cycles.
- Config writes: accepted only when state==IDLE and no input handshake that edge is irrelevant (write and acceptance in the same IDLE edge both take effect; the new coefficient is used by that computation since RUN reads w afterwards). cfg_we while busy: dropped, no side effect. cfg_addr > N_FEAT: dropped.
- No special NaN/Inf/denormal handling beyond that of IEEE754_multiplier/IEEE754_adder.
- Reset mid-RUN or mid-DONE: computation discarded, out_valid falls immediately (async), coefficients revert to parameter values.

Test Plan:
- Reset defaults, all x=0.0 -> after 9 cycles out_valid=1, y=32'hC3C00E4C; handshake returns in_ready=1 next cycle.
- Write w[0..8]=32'h3F800000, bias=32'h00000000 in IDLE, x all 1.0 -> y=32'h41100000 (9.0) exactly 9 edges after acceptance.
- Hold out_ready=0 for 5 cycles after out_valid -> y and out_valid stable, in_ready=0, in_valid ignored; release -> IDLE next edge.
- cfg_we w[0]=32'h40000000 during RUN with all weights 1.0, bias 0, x all 1.0 -> y=9.0 (write dropped); repeat after IDLE -> y=10.0 (32'h41200000).
- Assert rst at 4th RUN cycle -> out_valid=0, in_ready=1 immediately, weights back to W_INIT (re-run zero vector gives 32'hC3C00E4C).
- Back-to-back 20 random vectors with out_ready=1 -> every y matches sequential-order float model bit-exactly, period 11 cycles.
